// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: grants one producer at a time a bounded burst
// into a shared FIFO, stalling on FIFO full without releasing the grant.
module fifo_wr_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   parameter int BURST = 4,
   parameter int CW    = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rest,
   input  logic [NREQ-1:0]           i_req,
   input  logic [NREQ*WIDTH-1:0]     i_data,
   input  logic                      i_full,
   output logic [NREQ-1:0]           o_gnt,
   output logic [NREQ-1:0]           o_ack,
   output logic                      o_wen,
   output logic [WIDTH-1:0]          o_wdata,
   output logic                      o_busy,
   output logic                      o_state,
   output logic [$clog2(NREQ)-1:0]   o_rr_ptr,
   output logic [CW-1:0]             o_cnt
);

   localparam int IW = $clog2(NREQ);
   localparam logic [IW:0]   NREQ_W = (IW+1)'(NREQ);
   localparam logic [IW-1:0] LAST_IDX = IW'(NREQ-1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST-1);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t          state, state_n;
   logic [IW-1:0]   gnt_idx, gnt_idx_n;
   logic [IW-1:0]   rr_ptr, rr_ptr_n;
   logic [CW-1:0]   cnt, cnt_n;

   logic [IW-1:0]   pick;
   logic [IW:0]     sum;
   logic [IW-1:0]   ptr_after;
   logic [NREQ-1:0] gnt_onehot;
   logic            beat;

   // Walk downward so the lowest offset from rr_ptr is the last (winning) hit.
   always_comb begin
      pick = '0;
      sum  = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         sum = {1'b0, rr_ptr} + (IW+1)'(i);
         if (sum >= NREQ_W) sum = sum - NREQ_W;
         if (i_req[sum[IW-1:0]]) pick = sum[IW-1:0];
      end
   end

   assign ptr_after  = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
   assign gnt_onehot = NREQ'(1) << gnt_idx;
   assign beat       = (state == GRANT) & i_req[gnt_idx] & ~i_full & ~i_rest;

   assign o_gnt    = (state == GRANT) ? gnt_onehot : '0;
   assign o_ack    = beat ? gnt_onehot : '0;
   assign o_wen    = beat;
   assign o_wdata  = i_data[gnt_idx*WIDTH +: WIDTH];
   assign o_busy   = (state == GRANT);
   assign o_state  = state;
   assign o_rr_ptr = rr_ptr;
   assign o_cnt    = cnt;

   always_comb begin
      state_n   = state;
      gnt_idx_n = gnt_idx;
      rr_ptr_n  = rr_ptr;
      cnt_n     = cnt;
      case (state)
         IDLE: begin
            if (|i_req) begin
               gnt_idx_n = pick;
               cnt_n     = '0;
               state_n   = GRANT;
            end
         end
         GRANT: begin
            // Full with the request held is a pure stall: everything holds.
            if (!i_req[gnt_idx]) begin
               state_n  = IDLE;
               rr_ptr_n = ptr_after;
            end else if (beat) begin
               if (cnt == LAST_BEAT) begin
                  state_n  = IDLE;
                  rr_ptr_n = ptr_after;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rest) begin
         state   <= IDLE;
         gnt_idx <= '0;
         rr_ptr  <= '0;
         cnt     <= '0;
      end else begin
         state   <= state_n;
         gnt_idx <= gnt_idx_n;
         rr_ptr  <= rr_ptr_n;
         cnt     <= cnt_n;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level reference model and an expected-write queue.
module tb_fifo_wr_arbiter;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;
   localparam int BURST = 4;
   localparam int CW    = 4;
   localparam int IW    = 2;
   localparam int DEPTH = 10;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] data;
   logic                  full;
   logic [NREQ-1:0]       o_gnt, o_ack;
   logic                  o_wen, o_busy, o_state;
   logic [WIDTH-1:0]      o_wdata;
   logic [IW-1:0]         o_rr_ptr;
   logic [CW-1:0]         o_cnt;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST), .CW(CW)) dut (
      .i_clk(clk), .i_rest(rst), .i_req(req), .i_data(data), .i_full(full),
      .o_gnt(o_gnt), .o_ack(o_ack), .o_wen(o_wen), .o_wdata(o_wdata),
      .o_busy(o_busy), .o_state(o_state), .o_rr_ptr(o_rr_ptr), .o_cnt(o_cnt)
   );

   int checks = 0;
   int errors = 0;

   // reference model: who holds the grant, beats taken, next-search start
   bit m_busy;
   int m_idx, m_ptr, m_cnt;

   logic [WIDTH-1:0] exp_q[$];
   int               dut_gnt_log[$];
   logic [NREQ-1:0]  prev_gnt;
   int               wr_count;
   int               ack_cnt[NREQ];
   bit               dut_wen;
   int               level;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic settle();
      logic [NREQ-1:0]  eg, ea;
      bit               eb;
      logic [WIDTH-1:0] w;
      for (int k = 0; k < NREQ; k++) data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
      #1;
      eb = m_busy && req[m_idx] && !full && !rst;
      eg = m_busy ? (NREQ'(1) << m_idx) : '0;
      ea = eb ? eg : '0;
      chk("gnt", o_gnt, eg);
      chk("ack", o_ack, ea);
      chk("wen", o_wen, eb);
      chk("busy", o_busy, m_busy);
      chk("state", o_state, m_busy);
      chk("rr_ptr", o_rr_ptr, m_ptr);
      chk("cnt", o_cnt, m_cnt);
      if (eb) exp_q.push_back(data[m_idx*WIDTH +: WIDTH]);
      dut_wen = (o_wen === 1'b1);
      if (dut_wen) begin
         wr_count++;
         if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("wdata", o_wdata, w);
         end else begin
            chk("wdata_unexpected", o_wen, 0);
         end
      end
      for (int k = 0; k < NREQ; k++) if (o_ack[k] === 1'b1) ack_cnt[k]++;
      if (prev_gnt === '0 && o_gnt !== '0)
         for (int k = 0; k < NREQ; k++) if (o_gnt[k] === 1'b1) dut_gnt_log.push_back(k);
      prev_gnt = o_gnt;
   endtask

   task automatic tick();
      bit found;
      int cand;
      @(posedge clk);
      if (rst) begin
         m_busy = 0; m_ptr = 0; m_cnt = 0;
      end else if (!m_busy) begin
         found = 0;
         for (int k = 0; k < NREQ; k++) begin
            cand = (m_ptr + k) % NREQ;
            if (!found && req[cand]) begin
               found = 1;
               m_idx = cand;
            end
         end
         if (found) begin
            m_busy = 1;
            m_cnt  = 0;
         end
      end else if (!req[m_idx]) begin
         m_busy = 0;
         m_ptr  = (m_idx + 1) % NREQ;
      end else if (!full) begin
         if (m_cnt == BURST - 1) begin
            m_busy = 0;
            m_ptr  = (m_idx + 1) % NREQ;
         end else begin
            m_cnt++;
         end
      end
      @(negedge clk);
   endtask

   task automatic cycle();
      settle();
      tick();
   endtask

   task automatic clear_stats();
      wr_count = 0;
      dut_gnt_log.delete();
      for (int k = 0; k < NREQ; k++) ack_cnt[k] = 0;
   endtask

   int exp_order[5] = '{0, 1, 2, 3, 0};
   int wrap_order[3] = '{3, 0, 3};

   initial begin
      rst = 1'b1; req = '1; full = 1'b0; data = '0; prev_gnt = '0;
      m_busy = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
      clear_stats();
      @(posedge clk);
      @(negedge clk);

      // reset held two cycles with every request raised
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("rst_gnt", o_gnt, 0);
         chk("rst_wen", o_wen, 0);
         chk("rst_busy", o_busy, 0);
         tick();
      end

      // fairness: four continuous requesters
      rst = 1'b0;
      clear_stats();
      for (int i = 0; i < 20; i++) cycle();
      chk("fair_beats_in_20", wr_count, 16);
      for (int k = 0; k < NREQ; k++) chk("fair_acks", ack_cnt[k], 4);
      cycle();
      cycle();
      chk("fair_grants", dut_gnt_log.size(), 5);
      for (int k = 0; k < 5; k++) chk("fair_order", dut_gnt_log[k], exp_order[k]);
      req = '0;
      cycle();

      // back-pressure on requester 2 after its first beat
      rst = 1'b1; cycle(); rst = 1'b0;
      req = 4'b0100;
      cycle();
      cycle();
      full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("bp_cnt_hold", o_cnt, 1);
         chk("bp_no_wen", o_wen, 0);
         chk("bp_gnt_hold", o_gnt, 4'b0100);
         tick();
      end
      full = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      req = '0;
      cycle();

      // early release by requester 1 with 0 and 3 waiting
      rst = 1'b1; cycle(); rst = 1'b0;
      req = 4'b0001; cycle();
      req = 4'b0000; cycle();
      req = 4'b1011; cycle();
      cycle();
      cycle();
      req = 4'b1001; cycle();
      settle();
      chk("early_idle", o_busy, 0);
      chk("early_ptr", o_rr_ptr, 2);
      tick();

      // reset pulsed on the third beat of requester 3's grant
      settle();
      chk("early_next_gnt", o_gnt, 4'b1000);
      tick();
      cycle();
      rst = 1'b1;
      settle();
      chk("midrst_no_wen", o_wen, 0);
      chk("midrst_no_ack", o_ack, 0);
      tick();
      rst = 1'b0; req = '0;
      settle();
      chk("midrst_gnt", o_gnt, 0);
      chk("midrst_ptr", o_rr_ptr, 0);
      tick();

      // wrap-around between requesters 3 and 0 into a filling FIFO
      req = 4'b0100; cycle();
      req = 4'b0000; cycle();
      req = 4'b1001;
      clear_stats();
      level = 0;
      for (int i = 0; i < 30; i++) begin
         full = (level >= DEPTH);
         settle();
         if (full) chk("wrap_no_wen_full", o_wen, 0);
         tick();
         if (dut_wen) level++;
      end
      chk("wrap_writes", wr_count, DEPTH);
      chk("wrap_grants", dut_gnt_log.size(), 3);
      for (int k = 0; k < 3; k++) chk("wrap_order", dut_gnt_log[k], wrap_order[k]);
      full = 1'b0;
      rst = 1'b1; cycle(); rst = 1'b0;

      // random traffic
      for (int i = 0; i < 400; i++) begin
         rst  = ($urandom_range(0, 49) == 0);
         full = ($urandom_range(0, 3) == 0);
         for (int k = 0; k < NREQ; k++) req[k] = ($urandom_range(0, 3) != 0);
         cycle();
      end

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
